// File: rtl/sync_fifo.sv
// Single-clock byte FIFO with registered (non-show-ahead) read data.
// Status flags are registered from the next-occupancy value; overflow/underflow are sticky.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data,
  input  logic             wrreq,
  input  logic             rdreq,
  output logic [WIDTH-1:0] q,
  output logic             empty,
  output logic             full,
  output logic [AW-1:0]    usedw,
  output logic             overflow,
  output logic             underflow
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;
  logic [AW:0]      count_nxt;
  logic             rd_ok;
  logic             wr_ok;

  // A write into a full FIFO is still taken when a read frees a slot the same cycle.
  always_comb begin
    rd_ok     = rdreq && !empty;
    wr_ok     = wrreq && (!full || rd_ok);
    count_nxt = count + {{AW{1'b0}}, wr_ok} - {{AW{1'b0}}, rd_ok};
  end

  always_ff @(posedge clk) begin
    if (wr_ok && reset) begin
      mem[wr_ptr] <= data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      q         <= '0;
      empty     <= 1'b1;
      full      <= 1'b0;
      usedw     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_ok) begin
        q      <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (wrreq && !wr_ok) begin
        overflow <= 1'b1;
      end
      if (rdreq && empty) begin
        underflow <= 1'b1;
      end
      count <= count_nxt;
      full  <= (count_nxt == (AW+1)'(DEPTH));
      empty <= (count_nxt == '0);
      usedw <= count_nxt[AW-1:0];
    end
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: the driver queues expected read bytes with the
// cycle they are due; a negedge monitor pops and compares q independently.
module tb_sync_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data;
  logic       wrreq;
  logic       rdreq;
  logic [7:0] q;
  logic       empty;
  logic       full;
  logic [1:0] usedw;
  logic       overflow;
  logic       underflow;

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;

  logic [7:0] exp_q [$];
  int         due_q [$];
  logic [7:0] last_q = 8'h00;
  bit         mon_en = 1'b0;

  sync_fifo #(.WIDTH(8), .DEPTH(4), .AW(2)) dut (
    .clk(clk), .reset(reset), .data(data), .wrreq(wrreq), .rdreq(rdreq),
    .q(q), .empty(empty), .full(full), .usedw(usedw),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle = cycle + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // One clock: drive inputs, optionally register an expected read byte, then step past the edge.
  task automatic cyc(input logic wr, input logic rd, input logic [7:0] d,
                     input bit exp_rd, input logic [7:0] exp_d);
    wrreq = wr;
    rdreq = rd;
    data  = d;
    if (exp_rd) begin
      exp_q.push_back(exp_d);
      due_q.push_back(cycle + 1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic status(input string tag, input logic e, input logic f, input logic [1:0] u);
    chk({tag, "_empty"}, empty, e);
    chk({tag, "_full"},  full,  f);
    chk({tag, "_usedw"}, usedw, u);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (due_q.size() > 0 && due_q[0] == cycle) begin
        last_q = exp_q.pop_front();
        void'(due_q.pop_front());
        chk("q_data", q, last_q);
      end else begin
        chk("q_hold", q, last_q);
      end
    end
  end

  initial begin
    reset = 1'b0; wrreq = 1'b1; rdreq = 1'b1; data = 8'hFF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    status("rst", 1'b1, 1'b0, 2'd0);
    chk("rst_q", q, 8'h00);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_udf", underflow, 1'b0);
    reset  = 1'b1;
    mon_en = 1'b1;

    cyc(1, 0, 8'h11, 0, 8'h00); status("fill1", 1'b0, 1'b0, 2'd1);
    cyc(1, 0, 8'h22, 0, 8'h00); status("fill2", 1'b0, 1'b0, 2'd2);
    cyc(1, 0, 8'h33, 0, 8'h00); status("fill3", 1'b0, 1'b0, 2'd3);
    cyc(1, 0, 8'h44, 0, 8'h00); status("fill4", 1'b0, 1'b1, 2'd0);
    chk("fill_ovf", overflow, 1'b0);

    cyc(1, 0, 8'h55, 0, 8'h00); status("ovf", 1'b0, 1'b1, 2'd0);
    chk("ovf_flag", overflow, 1'b1);

    cyc(0, 1, 8'h00, 1, 8'h11); status("drain1", 1'b0, 1'b0, 2'd3);
    cyc(0, 1, 8'h00, 1, 8'h22);
    cyc(0, 1, 8'h00, 1, 8'h33);
    cyc(0, 1, 8'h00, 1, 8'h44); status("drain4", 1'b1, 1'b0, 2'd0);
    chk("drain_udf", underflow, 1'b0);

    cyc(0, 1, 8'h00, 0, 8'h00); status("udf", 1'b1, 1'b0, 2'd0);
    chk("udf_flag", underflow, 1'b1);
    chk("udf_q", q, 8'h44);

    cyc(1, 0, 8'hAA, 0, 8'h00);
    cyc(1, 0, 8'hBB, 0, 8'h00); status("two", 1'b0, 1'b0, 2'd2);
    cyc(1, 1, 8'hCC, 1, 8'hAA); status("rw1", 1'b0, 1'b0, 2'd2);
    cyc(1, 1, 8'hCC, 1, 8'hBB); status("rw2", 1'b0, 1'b0, 2'd2);
    cyc(1, 1, 8'hCC, 1, 8'hCC); status("rw3", 1'b0, 1'b0, 2'd2);
    cyc(1, 0, 8'hDD, 0, 8'h00);
    cyc(1, 0, 8'hEE, 0, 8'h00); status("refull", 1'b0, 1'b1, 2'd0);
    cyc(1, 1, 8'hF0, 1, 8'hCC); status("rwfull", 1'b0, 1'b1, 2'd0);
    cyc(0, 1, 8'h00, 1, 8'hCC);
    cyc(0, 1, 8'h00, 1, 8'hDD);
    cyc(0, 1, 8'h00, 1, 8'hEE);
    cyc(0, 1, 8'h00, 1, 8'hF0); status("rwdrain", 1'b1, 1'b0, 2'd0);

    cyc(1, 1, 8'h77, 0, 8'h00); status("rwempty", 1'b0, 1'b0, 2'd1);
    cyc(0, 1, 8'h00, 1, 8'h77); status("rwempty_rd", 1'b1, 1'b0, 2'd0);

    cyc(1, 0, 8'h00, 0, 8'h00);
    for (int i = 1; i < 10; i++) begin
      cyc(1, 1, 8'(i), 1, 8'(i - 1));
      status("wrap", 1'b0, 1'b0, 2'd1);
    end
    cyc(0, 1, 8'h00, 1, 8'h09); status("wrap_end", 1'b1, 1'b0, 2'd0);
    cyc(0, 0, 8'h00, 0, 8'h00);
    cyc(0, 0, 8'h00, 0, 8'h00);
    chk("sb_empty", exp_q.size(), 0);

    mon_en = 1'b0;
    reset  = 1'b0;
    cyc(1, 1, 8'h12, 0, 8'h00);
    status("rst2", 1'b1, 1'b0, 2'd0);
    chk("rst2_ovf", overflow, 1'b0);
    chk("rst2_udf", underflow, 1'b0);
    chk("rst2_q", q, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
